// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the PLL configuration controller.
package pll_cfg_pkg;

  localparam int ODIV_W      = 10;
  localparam int DUTY_W      = 10;
  localparam int PHASE_W     = 13;
  localparam int LOCK_STABLE = 8;
  localparam int STABLE_W    = $clog2(LOCK_STABLE + 1);
  localparam int CNT_W       = 17;
  localparam int RETRY_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    PRST,
    WLOCK,
    UNGATE,
    FAIL
  } state_t;

  typedef struct packed {
    logic [ODIV_W-1:0]  odiv;
    logic [DUTY_W-1:0]  duty;
    logic [PHASE_W-1:0] phase;
  } pll_cfg_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_cfg_ctrl.sv
// PLL reconfiguration sequencer: gates the output clocks, pulses the PLL reset
// with new divider/duty/phase values, then waits for a stable lock.
module pll_cfg_ctrl
  import pll_cfg_pkg::*;
#(
  parameter logic [ODIV_W-1:0]  RST_ODIV     = 10'd100,
  parameter logic [DUTY_W-1:0]  RST_DUTY     = 10'd100,
  parameter logic [PHASE_W-1:0] RST_PHASE    = 13'd16,
  parameter int                 GATE_CYCLES  = 4,
  parameter int                 RST_CYCLES   = 16,
  parameter int                 LOCK_TIMEOUT = 65535,
  parameter int                 MAX_RETRY    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ODIV_W-1:0]  cfg_odiv,
  input  logic [DUTY_W-1:0]  cfg_duty,
  input  logic [PHASE_W-1:0] cfg_phase,
  output logic [ODIV_W-1:0]  dyn_odiv,
  output logic [DUTY_W-1:0]  dyn_duty,
  output logic [PHASE_W-1:0] dyn_phase,
  output logic               pll_rst,
  output logic               clkout_gate,
  input  logic               pll_lock,
  output logic               done,
  output logic               err,
  output logic               lock_lost
);

  localparam logic [CNT_W-1:0]    GATE_LAST    = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX    = RETRY_W'(MAX_RETRY);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [STABLE_W-1:0] stable_cnt;
  logic [RETRY_W-1:0]  retries;
  pll_cfg_t            shadow;
  logic                lk, lk_prev;

  logic cnt_clr, start, take_cfg, load_dyn, retry_inc, set_err, done_d, lost_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lk)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRST;
    else        state <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    cnt_clr   = 1'b0;
    take_cfg  = 1'b0;
    load_dyn  = 1'b0;
    retry_inc = 1'b0;
    set_err   = 1'b0;
    done_d    = 1'b0;
    lost_d    = 1'b0;
    case (state)
      IDLE: begin
        // Lock loss outranks a request arriving in the same cycle.
        if (lk_prev && !lk) begin
          lost_d  = 1'b1;
          state_d = GATE;
          cnt_clr = 1'b1;
        end else if (cfg_valid) begin
          take_cfg = 1'b1;
          state_d  = GATE;
          cnt_clr  = 1'b1;
        end
      end
      GATE: begin
        if (cnt == GATE_LAST) begin
          state_d  = PRST;
          load_dyn = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      PRST: begin
        if (cnt == RST_LAST) begin
          state_d = WLOCK;
          cnt_clr = 1'b1;
        end
      end
      WLOCK: begin
        if (lk && stable_cnt == STABLE_LAST) begin
          state_d = UNGATE;
          cnt_clr = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_clr = 1'b1;
          if (retries < RETRY_MAX) begin
            retry_inc = 1'b1;
            load_dyn  = 1'b1;
            state_d   = PRST;
          end else begin
            set_err = 1'b1;
            state_d = FAIL;
          end
        end
      end
      UNGATE: begin
        if (cnt == GATE_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      FAIL: begin
        if (cfg_valid) begin
          take_cfg = 1'b1;
          state_d  = GATE;
          cnt_clr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign start       = cnt_clr && (state_d == GATE);
  assign cfg_ready   = (state == IDLE) || (state == FAIL);
  assign pll_rst     = (state == PRST);
  assign clkout_gate = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      stable_cnt <= '0;
      retries    <= '0;
      lk_prev    <= 1'b0;
      shadow     <= {RST_ODIV, RST_DUTY, RST_PHASE};
      dyn_odiv   <= RST_ODIV;
      dyn_duty   <= RST_DUTY;
      dyn_phase  <= RST_PHASE;
      err        <= 1'b0;
      done       <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      lk_prev   <= lk;
      done      <= done_d;
      lock_lost <= lost_d;

      if (cnt_clr)                           cnt <= '0;
      else if (state != IDLE && state != FAIL) cnt <= cnt + 1'b1;

      // Consecutive-lock counter; any low sample restarts it.
      if (state != WLOCK || !lk)         stable_cnt <= '0;
      else if (stable_cnt != STABLE_LAST) stable_cnt <= stable_cnt + 1'b1;

      if (start)          retries <= '0;
      else if (retry_inc) retries <= retries + 1'b1;

      if (take_cfg) shadow <= {cfg_odiv, cfg_duty, cfg_phase};

      // The PLL only ever sees new values at the start of a reset pulse.
      if (load_dyn) begin
        dyn_odiv  <= shadow.odiv;
        dyn_duty  <= shadow.duty;
        dyn_phase <= shadow.phase;
      end

      if (take_cfg)     err <= 1'b0;
      else if (set_err) err <= 1'b1;
    end
  end

endmodule
